// File: rtl/cla_pkg.sv
// Shared sizing helpers for the pipelined carry-lookahead adder: segment width,
// lookahead group count, parameter legality and skew-register packing.
package cla_pkg;

  function automatic int seg_width(input int width, input int stages);
    return width / stages;
  endfunction

  function automatic int group_count(input int seg, input int block);
    return seg / block;
  endfunction

  function automatic bit params_legal(input int width, input int stages, input int block);
    return (width > 0) && (stages > 0) && (block > 0) && ((width % (stages * block)) == 0);
  endfunction

  // Stage k keeps the not-yet-added B segments k+1..STAGES-1; slices are packed
  // back to back, so stage k starts after the slices of stages 0..k-1.
  function automatic int skew_ofs(input int width, input int seg, input int k);
    return k * width - (seg * k * (k + 1)) / 2;
  endfunction

  function automatic int skew_total(input int width, input int seg, input int stages);
    int t;
    t = skew_ofs(width, seg, stages - 1);
    return (t < 1) ? 1 : t;
  endfunction

endpackage

// File: rtl/cla_seg.sv
// Combinational SEG-bit adder: BLOCK-bit generate/propagate groups feeding a
// second-level lookahead across the groups of the segment.
module cla_seg
  import cla_pkg::*;
#(
  parameter int SEG   = 16,
  parameter int BLOCK = 4
) (
  input  logic [SEG-1:0] a_i,
  input  logic [SEG-1:0] b_i,
  input  logic           cin_i,
  output logic [SEG-1:0] sum_o,
  output logic           cout_o,
  output logic           cmsb_o
);

  localparam int NG = group_count(SEG, BLOCK);

  logic [SEG-1:0] g;
  logic [SEG-1:0] p;
  logic [SEG-1:0] c;
  logic [NG-1:0]  gg;
  logic [NG-1:0]  pg;
  logic [NG:0]    cg;

  assign g = a_i & b_i;
  assign p = a_i ^ b_i;

  for (genvar gi = 0; gi < NG; gi++) begin : g_grp
    logic             gk;
    logic             pk;
    logic [BLOCK-1:0] cb;

    always_comb begin
      gk = 1'b0;
      pk = 1'b1;
      for (int j = 0; j < BLOCK; j++) begin
        gk = g[gi*BLOCK+j] | (p[gi*BLOCK+j] & gk);
        pk = pk & p[gi*BLOCK+j];
      end
    end

    // Bit carries inside the group only depend on the group carry-in.
    always_comb begin
      logic cv;
      cv = cg[gi];
      cb = '0;
      for (int j = 0; j < BLOCK; j++) begin
        cb[j] = cv;
        cv    = g[gi*BLOCK+j] | (p[gi*BLOCK+j] & cv);
      end
    end

    assign gg[gi]                = gk;
    assign pg[gi]                = pk;
    assign c[gi*BLOCK +: BLOCK]  = cb;
  end

  always_comb begin
    logic cv;
    cv    = cin_i;
    cg    = '0;
    cg[0] = cin_i;
    for (int k = 0; k < NG; k++) begin
      cv      = gg[k] | (pg[k] & cv);
      cg[k+1] = cv;
    end
  end

  assign sum_o  = p ^ c;
  assign cout_o = cg[NG];
  assign cmsb_o = c[SEG-1];

endmodule

// File: rtl/cla_pipe_adder.sv
// Pipelined WIDTH-bit carry-lookahead adder/subtractor with valid/ready on both
// sides; one SEG-bit segment is added per register stage.
module cla_pipe_adder
  import cla_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2,
  parameter int BLOCK  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int SEG = seg_width(WIDTH, STAGES);
  localparam int SKW = skew_total(WIDTH, SEG, STAGES);

  if (!params_legal(WIDTH, STAGES, BLOCK)) begin : g_bad_params
    $error("cla_pipe_adder: WIDTH must be a positive multiple of STAGES*BLOCK");
  end

  logic              adv;
  logic [WIDTH-1:0]  b_eff;
  logic              cin_eff;
  logic [STAGES-1:0] vld_q, vld_d;
  logic [STAGES-1:0] c_q, c_d;
  logic [STAGES-1:0] cm_d;
  logic [WIDTH-1:0]  acc_q [STAGES];
  logic [WIDTH-1:0]  acc_d [STAGES];
  logic [SKW-1:0]    skew_q, skew_d;
  logic              ovf_q, ovf_d;
  logic              unused_cmsb;

  // One global enable: the whole pipe moves unless the output is blocked.
  assign adv      = !vld_q[STAGES-1] || out_ready;
  assign in_ready = adv;

  assign b_eff   = sub ? ~b : b;
  assign cin_eff = sub | cin;

  // acc carries completed sum segments below segment gi and untouched A above it.
  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    logic [WIDTH-1:0] acc_in;
    logic [WIDTH-1:0] acc_nx;
    logic [SEG-1:0]   seg_b;
    logic [SEG-1:0]   seg_sum;
    logic             seg_c;

    if (gi == 0) begin : g_head
      assign acc_in    = a;
      assign seg_b     = b_eff[SEG-1:0];
      assign seg_c     = cin_eff;
      assign vld_d[gi] = in_valid;
    end else begin : g_body
      assign acc_in    = acc_q[gi-1];
      assign seg_b     = skew_q[skew_ofs(WIDTH, SEG, gi-1) +: SEG];
      assign seg_c     = c_q[gi-1];
      assign vld_d[gi] = vld_q[gi-1];
    end

    if (gi < STAGES - 1) begin : g_skew
      localparam int REM = WIDTH - (gi + 1) * SEG;
      if (gi == 0) begin : g_first
        assign skew_d[skew_ofs(WIDTH, SEG, gi) +: REM] = b_eff[WIDTH-1:SEG];
      end else begin : g_next
        assign skew_d[skew_ofs(WIDTH, SEG, gi) +: REM] =
          skew_q[skew_ofs(WIDTH, SEG, gi-1) + SEG +: REM];
      end
    end

    cla_seg #(
      .SEG   (SEG),
      .BLOCK (BLOCK)
    ) u_seg (
      .a_i    (acc_in[gi*SEG +: SEG]),
      .b_i    (seg_b),
      .cin_i  (seg_c),
      .sum_o  (seg_sum),
      .cout_o (c_d[gi]),
      .cmsb_o (cm_d[gi])
    );

    always_comb begin
      acc_nx                = acc_in;
      acc_nx[gi*SEG +: SEG] = seg_sum;
    end

    assign acc_d[gi] = acc_nx;
  end

  if (STAGES == 1) begin : g_no_skew
    logic unused_skew;
    assign skew_d      = '0;
    assign unused_skew = ^skew_q;
  end

  // Only the last segment's MSB carry-in matters for signed overflow.
  assign unused_cmsb = ^cm_d;
  assign ovf_d       = cm_d[STAGES-1] ^ c_d[STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q  <= '0;
      c_q    <= '0;
      skew_q <= '0;
      ovf_q  <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        acc_q[k] <= '0;
      end
    end else if (adv) begin
      vld_q  <= vld_d;
      skew_q <= skew_d;
      for (int k = 0; k < STAGES; k++) begin
        if (vld_d[k]) begin
          acc_q[k] <= acc_d[k];
          c_q[k]   <= c_d[k];
        end
      end
      if (vld_d[STAGES-1]) begin
        ovf_q <= ovf_d;
      end
    end
  end

  assign out_valid = vld_q[STAGES-1];
  assign sum       = acc_q[STAGES-1];
  assign cout      = c_q[STAGES-1];
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Bench for cla_pipe_adder: directed 32-bit/2-stage cases plus a throttled random
// stream on a 64-bit/4-stage instance against an arithmetic reference model.
module tb_cla_pipe_adder;

  logic clk = 1'b0;
  logic rst;

  logic        iv32, ir32, ov32, or32, cin32, sub32, co32, of32;
  logic [31:0] a32, b32, s32;

  logic        iv64, ir64, ov64, or64, cin64, sub64, co64, of64;
  logic [63:0] a64, b64, s64;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cla_pipe_adder #(.WIDTH(32), .STAGES(2), .BLOCK(4)) dut32 (
    .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32), .a(a32), .b(b32),
    .cin(cin32), .sub(sub32), .out_valid(ov32), .out_ready(or32), .sum(s32),
    .cout(co32), .ovf(of32)
  );

  cla_pipe_adder #(.WIDTH(64), .STAGES(4), .BLOCK(4)) dut64 (
    .clk(clk), .rst(rst), .in_valid(iv64), .in_ready(ir64), .a(a64), .b(b64),
    .cin(cin64), .sub(sub64), .out_valid(ov64), .out_ready(or64), .sum(s64),
    .cout(co64), .ovf(of64)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: A + B + cin, or A - B, as plain 65-bit arithmetic; signed
  // overflow when both addends share a sign that the result does not.
  function automatic logic [65:0] model64(input logic [63:0] a, input logic [63:0] b,
                                          input logic ci, input logic sb);
    logic [63:0] bb;
    logic [64:0] t;
    logic        v;
    bb = sb ? ~b : b;
    t  = {1'b0, a} + {1'b0, bb} + (sb ? 65'd1 : {64'd0, ci});
    v  = (a[63] == bb[63]) && (t[63] != a[63]);
    return {v, t};
  endfunction

  task automatic op32(input string tag, input logic [31:0] a, input logic [31:0] b,
                      input logic ci, input logic sb,
                      input logic [31:0] es, input logic ec, input logic eo);
    int n;
    a32 = a; b32 = b; cin32 = ci; sub32 = sb; iv32 = 1'b1; or32 = 1'b1;
    #1;
    check({tag, "_in_ready"}, ir32, 1'b1);
    @(posedge clk); #1;
    iv32 = 1'b0;
    n = 1;
    while (!ov32 && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_latency"}, n, 2);
    check({tag, "_sum"}, s32, es);
    check({tag, "_cout"}, co32, ec);
    check({tag, "_ovf"}, of32, eo);
    $display("op %s: a=%h b=%h cin=%0d sub=%0d -> sum=%h cout=%0d ovf=%0d lat=%0d",
             tag, a, b, ci, sb, s32, co32, of32, n);
    @(posedge clk); #1;
    check({tag, "_drained"}, ov32, 1'b0);
  endtask

  initial begin
    logic [31:0] got[$];
    logic [31:0] held;
    logic [65:0] exp_q[$];
    logic [65:0] e;
    int sent, stall_left, stale, recv, cyc;

    rst = 1'b1;
    iv32 = 1'b0; or32 = 1'b1; a32 = '0; b32 = '0; cin32 = 1'b0; sub32 = 1'b0;
    iv64 = 1'b0; or64 = 1'b1; a64 = '0; b64 = '0; cin64 = 1'b0; sub64 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    check("rst32_out_valid", ov32, 1'b0);
    check("rst32_sum", s32, 32'd0);
    check("rst32_cout", co32, 1'b0);
    check("rst32_ovf", of32, 1'b0);
    check("rst32_in_ready", ir32, 1'b1);
    check("rst64_out_valid", ov64, 1'b0);
    check("rst64_flags", {of64, co64, s64}, 66'd0);

    op32("add_43_45",  32'd43,        32'd45, 1'b0, 1'b0, 32'd88,        1'b0, 1'b0);
    op32("add_wrap",   32'hFFFFFFFF,  32'd1,  1'b0, 1'b0, 32'h00000000,  1'b1, 1'b0);
    op32("add_ovf",    32'h7FFFFFFF,  32'd1,  1'b0, 1'b0, 32'h80000000,  1'b0, 1'b1);
    op32("sub_ovf",    32'h80000000,  32'd1,  1'b0, 1'b1, 32'h7FFFFFFF,  1'b1, 1'b1);
    op32("sub_borrow", 32'd5,         32'd7,  1'b0, 1'b1, 32'hFFFFFFFE,  1'b0, 1'b0);
    op32("sub_cin_ig", 32'd10,        32'd3,  1'b1, 1'b1, 32'd7,         1'b1, 1'b0);
    op32("add_cin",    32'h0000FFFF,  32'd0,  1'b1, 1'b0, 32'h00010000,  1'b0, 1'b0);

    // Back-to-back stream with a three-cycle consumer stall on the first result.
    sent = 0;
    stall_left = -1;
    held = '0;
    for (int cy = 0; cy < 20; cy++) begin
      if (ov32 && stall_left < 0) stall_left = 3;
      or32  = !(stall_left > 0);
      iv32  = (sent < 4);
      a32   = 32'(sent + 1);
      b32   = 32'(sent + 1);
      cin32 = 1'b0;
      sub32 = 1'b0;
      #1;
      if (stall_left > 0) begin
        check("stall_in_ready", ir32, 1'b0);
        check("stall_out_valid", ov32, 1'b1);
        if (stall_left < 3) check("stall_sum_hold", s32, held);
        held = s32;
        stall_left--;
      end
      if (ov32 && or32) begin
        got.push_back(s32);
        $display("stream out: sum=%0d", s32);
      end
      if (iv32 && ir32) sent++;
      @(posedge clk); #1;
    end
    iv32 = 1'b0;
    check("stream_count", got.size(), 4);
    for (int i = 0; i < got.size() && i < 4; i++) begin
      check("stream_order", got[i], 32'(2 * (i + 1)));
    end

    // Reset with two beats in flight: neither may ever reach the output.
    or32 = 1'b0; iv32 = 1'b1; a32 = 32'd100; b32 = 32'd1; cin32 = 1'b0; sub32 = 1'b0;
    @(posedge clk); #1;
    a32 = 32'd200;
    @(posedge clk); #1;
    iv32 = 1'b0;
    check("inflight_out_valid", ov32, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_out_valid", ov32, 1'b0);
    check("midrst_sum", s32, 32'd0);
    check("midrst_flags", {of32, co32}, 2'b00);
    check("midrst_in_ready", ir32, 1'b1);
    or32 = 1'b1;
    stale = 0;
    for (int cy = 0; cy < 6; cy++) begin
      @(posedge clk); #1;
      if (ov32) stale++;
    end
    check("midrst_no_stale", stale, 0);
    $display("reset mid-flight: stale results seen=%0d", stale);
    op32("post_rst", 32'h12345678, 32'h0FEDCBA9, 1'b0, 1'b0, 32'h22222221, 1'b0, 1'b0);

    // Random throttled stream on the 64-bit, 4-stage instance.
    sent = 0;
    recv = 0;
    cyc = 0;
    while (recv < 10000 && cyc < 80000) begin
      iv64 = (sent < 10000) && ($urandom_range(0, 9) < 8);
      or64 = ($urandom_range(0, 9) < 7);
      a64  = {$urandom, $urandom};
      case ($urandom_range(0, 3))
        0:       b64 = ~a64;
        1:       b64 = 64'd1;
        default: b64 = {$urandom, $urandom};
      endcase
      cin64 = 1'($urandom_range(0, 1));
      sub64 = 1'($urandom_range(0, 1));
      #1;
      if (ov64 && or64) begin
        if (exp_q.size() == 0) begin
          check("rnd_unexpected_result", exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          check("rnd_result", {of64, co64, s64}, e);
        end
        recv++;
        if (recv % 1000 == 0) $display("random: %0d results compared", recv);
      end
      if (iv64 && ir64) begin
        exp_q.push_back(model64(a64, b64, cin64, sub64));
        sent++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    iv64 = 1'b0;
    check("rnd_count", recv, 10000);
    check("rnd_leftover", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
